// File: rtl/vga_pkg.sv
// Shared VGA constants, color codes and rectangle-fill FSM state type.
package vga_pkg;

   localparam int VGA_MAX_H       = 640;
   localparam int VGA_MAX_V       = 480;
   localparam int VGA_MAX_H_WIDTH = $clog2(VGA_MAX_H);
   localparam int VGA_MAX_V_WIDTH = $clog2(VGA_MAX_V);

   // Writer and display side decode the same codes.
   typedef enum logic [1:0] {
      BLACK = 2'd0,
      WHITE = 2'd1,
      BLUE  = 2'd2,
      GREEN = 2'd3
   } color_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } rect_fill_state_t;

endpackage

// File: rtl/vga_rect_fill_if.sv
// Command handshake and frame-buffer write port of the rectangle-fill engine.
interface vga_rect_fill_if #(
   parameter int X_W     = 11,
   parameter int Y_W     = 11,
   parameter int COLOR_W = 2
) ();

   logic               cmd_valid_i;
   logic               cmd_ready_o;
   logic [X_W-1:0]     cmd_x_i;
   logic [Y_W-1:0]     cmd_y_i;
   logic [X_W-1:0]     cmd_w_i;
   logic [Y_W-1:0]     cmd_h_i;
   logic [COLOR_W-1:0] cmd_color_i;
   logic [X_W-1:0]     addr_x_o;
   logic [Y_W-1:0]     addr_y_o;
   logic [COLOR_W-1:0] color_o;
   logic               we_o;
   logic               wr_ready_i;
   logic               busy_o;
   logic               done_o;

   // Engine side.
   modport slave (
      input  cmd_valid_i, cmd_x_i, cmd_y_i, cmd_w_i, cmd_h_i, cmd_color_i, wr_ready_i,
      output cmd_ready_o, addr_x_o, addr_y_o, color_o, we_o, busy_o, done_o
   );

   // Command source / frame-buffer side.
   modport master (
      output cmd_valid_i, cmd_x_i, cmd_y_i, cmd_w_i, cmd_h_i, cmd_color_i, wr_ready_i,
      input  cmd_ready_o, addr_x_o, addr_y_o, color_o, we_o, busy_o, done_o
   );

endinterface

// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine: one pixel write per beat in row-major order, done pulse at end.
// Define VGA_RECT_FILL_CLIP_EN to clamp rectangles to the visible VGA area.
module vga_rect_fill
   import vga_pkg::*;
#(
   parameter int X_W     = 11,
   parameter int Y_W     = 11,
   parameter int COLOR_W = 2
) (
   input  logic            clk_i,
   input  logic            arst_i,
   vga_rect_fill_if.slave  bus
);

   localparam logic [X_W:0] X_ONE = (X_W+1)'(1);
   localparam logic [Y_W:0] Y_ONE = (Y_W+1)'(1);
`ifdef VGA_RECT_FILL_CLIP_EN
   localparam logic [X_W:0] CLIP_X = (X_W+1)'(VGA_MAX_H);
   localparam logic [Y_W:0] CLIP_Y = (Y_W+1)'(VGA_MAX_V);
`endif

   rect_fill_state_t   state_q, state_d;
   logic [X_W:0]       x_q, x_d, x0_q, x0_d, x_end_q, x_end_d;
   logic [Y_W:0]       y_q, y_d, y_end_q, y_end_d;
   logic [COLOR_W-1:0] color_q, color_d;
   logic               done_q, done_d;

   logic [X_W:0]       x_sum, x_lim;
   logic [Y_W:0]       y_sum, y_lim;
   logic               zero_cmd, row_end, last_beat;

   always_comb begin
      // End coordinates carry one extra bit so x0+w never overflows.
      x_sum = {1'b0, bus.cmd_x_i} + {1'b0, bus.cmd_w_i};
      y_sum = {1'b0, bus.cmd_y_i} + {1'b0, bus.cmd_h_i};
`ifdef VGA_RECT_FILL_CLIP_EN
      x_lim    = (x_sum > CLIP_X) ? CLIP_X : x_sum;
      y_lim    = (y_sum > CLIP_Y) ? CLIP_Y : y_sum;
      zero_cmd = (bus.cmd_w_i == '0) || (bus.cmd_h_i == '0) ||
                 ({1'b0, bus.cmd_x_i} >= CLIP_X) || ({1'b0, bus.cmd_y_i} >= CLIP_Y);
`else
      x_lim    = x_sum;
      y_lim    = y_sum;
      zero_cmd = (bus.cmd_w_i == '0) || (bus.cmd_h_i == '0);
`endif
      row_end   = (x_q + X_ONE) == x_end_q;
      last_beat = row_end && ((y_q + Y_ONE) == y_end_q);

      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      x0_d    = x0_q;
      x_end_d = x_end_q;
      y_end_d = y_end_q;
      color_d = color_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid_i) begin
               if (zero_cmd) begin
                  done_d = 1'b1;
               end else begin
                  x_d     = {1'b0, bus.cmd_x_i};
                  y_d     = {1'b0, bus.cmd_y_i};
                  x0_d    = {1'b0, bus.cmd_x_i};
                  x_end_d = x_lim;
                  y_end_d = y_lim;
                  color_d = bus.cmd_color_i;
                  state_d = ST_FILL;
               end
            end
         end
         ST_FILL: begin
            if (bus.wr_ready_i) begin
               if (row_end) begin
                  x_d = x0_q;
                  y_d = y_q + Y_ONE;
               end else begin
                  x_d = x_q + X_ONE;
               end
               if (last_beat) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         x0_q    <= '0;
         x_end_q <= '0;
         y_end_q <= '0;
         color_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         x0_q    <= x0_d;
         x_end_q <= x_end_d;
         y_end_q <= y_end_d;
         color_q <= color_d;
         done_q  <= done_d;
      end
   end

   assign bus.cmd_ready_o = (state_q == ST_IDLE);
   assign bus.we_o        = (state_q == ST_FILL);
   assign bus.busy_o      = (state_q == ST_FILL);
   assign bus.done_o      = done_q;
   assign bus.addr_x_o    = x_q[X_W-1:0];
   assign bus.addr_y_o    = y_q[Y_W-1:0];
   assign bus.color_o     = color_q;

endmodule
